// File: rtl/kyber_pkg.sv
// kyber_pkg
// Shared constants and types for the Kyber coefficient reduce/compress/pack
// datapath.
//   - Modulus and polynomial size (KYBER_Q, KYBER_N).
//   - Barrett reduction constants (BARRETT_V, BARRETT_SHIFT).
//   - Lane geometry (COEFF_W, LANES).
//   - The reduced-coefficient type coeff12_t.
//   - The reciprocal used for the exact divide-by-q in compression.
package kyber_pkg;

    localparam int KYBER_Q       = 3329;
    localparam int KYBER_N       = 256;
    localparam int BARRETT_V     = 20159;
    localparam int BARRETT_SHIFT = 26;
    localparam int COEFF_W       = 16;
    localparam int LANES         = 8;
    localparam int COEFF_RED_W   = 12;

    // Reduced coefficient, always in [0, KYBER_Q-1].
    typedef logic [COEFF_RED_W-1:0] coeff12_t;

    // floor(n / q) == (n * COMPRESS_M) >> COMPRESS_SHIFT for every n < 2^23.
    // The largest compression numerator is 3328 * 2^11 + 1664, which is
    // below 2^23. ceil(2^35 / q) overshoots 2^35 by less than 2^(35-23),
    // and that bound is what makes the quotient exact.
    localparam int     COMPRESS_SHIFT = 35;
    localparam longint COMPRESS_M     =
        ((64'sd1 <<< COMPRESS_SHIFT) + 64'(KYBER_Q) - 64'sd1) / 64'(KYBER_Q);

    // Barrett leaves a centred remainder; fold negatives up into [0, q).
    function automatic coeff12_t canonicalize(input logic signed [31:0] r);
        if (r < 32'sd0) begin
            return coeff12_t'(r + 32'(KYBER_Q));
        end else begin
            return coeff12_t'(r);
        end
    endfunction

endpackage

// File: rtl/coeff_reduce_compress.sv
// coeff_reduce_compress
// One coefficient lane, two registered stages:
//   stage 1: Barrett reduction of a signed 16-bit sum into [0, q)
//   stage 2: compression to D_BITS bits, round((2^d / q) * r) mod 2^d
// Ports:
//   iClk, iRst         clock, asynchronous active-high reset
//   iAdvReduce         load the stage-1 register (shared by all lanes)
//   iAdvCompress       load the stage-2 register (shared by all lanes)
//   iCoeff   [15:0]    signed coefficient sum
//   oComp    [d-1:0]   compressed coefficient (stage-2 register)
module coeff_reduce_compress
    import kyber_pkg::*;
#(
    parameter int D_BITS = 4
) (
    input  logic                      iClk,
    input  logic                      iRst,
    input  logic                      iAdvReduce,
    input  logic                      iAdvCompress,
    input  logic signed [COEFF_W-1:0] iCoeff,
    output logic        [D_BITS-1:0]  oComp
);

    logic signed [31:0] xExt;
    logic signed [31:0] prodS;
    logic signed [31:0] quotS;
    logic signed [31:0] remS;
    coeff12_t           reducedS;
    coeff12_t           reducedR;
    logic        [63:0] numS;
    logic        [63:0] scaledS;
    logic [D_BITS-1:0]  compS;
    logic [D_BITS-1:0]  compR;

    // Barrett reduction: x*v fits easily in 32 signed bits for 16-bit x.
    always_comb begin
        xExt     = 32'(iCoeff);
        prodS    = xExt * BARRETT_V + (32'sd1 <<< (BARRETT_SHIFT - 1));
        quotS    = prodS >>> BARRETT_SHIFT;
        remS     = xExt - quotS * KYBER_Q;
        reducedS = canonicalize(remS);
    end

    // Compression: the +(q-1)/2 term turns the floor into round-half-up,
    // and keeping only d bits maps r near q back onto 0.
    always_comb begin
        numS    = (64'(reducedR) << D_BITS) + 64'((KYBER_Q - 1) / 2);
        scaledS = numS * 64'(COMPRESS_M);
        compS   = D_BITS'(scaledS >> COMPRESS_SHIFT);
    end

    // Stage-1 register: reduced coefficient.
    always_ff @(posedge iClk or posedge iRst) begin
        if (iRst) begin
            reducedR <= '0;
        end else if (iAdvReduce) begin
            reducedR <= reducedS;
        end
    end

    // Stage-2 register: compressed coefficient.
    always_ff @(posedge iClk or posedge iRst) begin
        if (iRst) begin
            compR <= '0;
        end else if (iAdvCompress) begin
            compR <= compS;
        end
    end

    assign oComp = compR;

endmodule

// File: rtl/poly_reduce_compress_pack.sv
// poly_reduce_compress_pack
// Reduces 8 signed coefficient sums per beat mod q, compresses each to
// D_BITS bits and packs the bits LSB-first into 32-bit words, one
// polynomial (32 beats) per frame.
// Ports:
//   iClk, iRst            clock, asynchronous active-high reset
//   iCoeffs [127:0]       8 signed 16-bit sums, lane k in [16k+15:16k]
//   iValid / oReady       upstream handshake
//   oWord [31:0]          packed bits, LSB = earliest bit
//   oValid / iReady       downstream handshake
//   oLast                 marks the final word of a polynomial
//   oPolyCnt [15:0]       completed polynomials (only with
//                         KYBER_PACK_POLYCNT_EN defined)
module poly_reduce_compress_pack
    import kyber_pkg::*;
#(
    parameter int D_BITS    = 4,
    parameter int O_WIDTH   = 32,
    parameter int BUF_WIDTH = 128
) (
    input  logic                     iClk,
    input  logic                     iRst,
    input  logic [LANES*COEFF_W-1:0] iCoeffs,
    input  logic                     iValid,
    output logic                     oReady,
    output logic [O_WIDTH-1:0]       oWord,
    output logic                     oValid,
    input  logic                     iReady,
    output logic                     oLast
`ifdef KYBER_PACK_POLYCNT_EN
    ,
    output logic [15:0]              oPolyCnt
`endif
);

    localparam int BEAT_BITS      = LANES * D_BITS;
    localparam int CNT_W          = $clog2(BUF_WIDTH + 1);
    localparam int BEATS_PER_POLY = KYBER_N / LANES;
    localparam int BEAT_IDX_W     = $clog2(BEATS_PER_POLY);

    logic                  readyEnR;
    logic                  valid1R, last1R, valid2R, last2R;
    logic [BEAT_IDX_W-1:0] beatCntR;
    logic [BUF_WIDTH-1:0]  bufR, bufShS, bufNextS;
    logic [CNT_W-1:0]      cntR, cntShS, cntNextS;
    logic                  lastPendR;
    logic [BEAT_BITS-1:0]  beatS;
    logic                  emitS, packAcceptS, advCompressS, advReduceS;

    // Stall chain: each stage moves when the slot below is empty or draining.
    always_comb begin
        emitS        = oValid && iReady;
        cntShS       = emitS ? (cntR - CNT_W'(O_WIDTH)) : cntR;
        bufShS       = emitS ? (bufR >> O_WIDTH) : bufR;
        packAcceptS  = valid2R && (cntShS < CNT_W'(O_WIDTH));
        advCompressS = !valid2R || packAcceptS;
        advReduceS   = readyEnR && (!valid1R || advCompressS);
    end

    // Append the new beat above the bits left after this cycle's shift.
    always_comb begin
        bufNextS = bufShS;
        cntNextS = cntShS;
        if (packAcceptS) begin
            bufNextS = bufShS | (BUF_WIDTH'(beatS) << cntShS);
            cntNextS = cntShS + CNT_W'(BEAT_BITS);
        end else begin
            bufNextS = bufShS;
            cntNextS = cntShS;
        end
    end

    for (genvar k = 0; k < LANES; k++) begin : gLane
        coeff_reduce_compress #(.D_BITS(D_BITS)) uLane (
            .iClk         (iClk),
            .iRst         (iRst),
            .iAdvReduce   (advReduceS),
            .iAdvCompress (advCompressS),
            .iCoeff       (iCoeffs[COEFF_W*k +: COEFF_W]),
            .oComp        (beatS[D_BITS*k +: D_BITS])
        );
    end

    // Keeps oReady low until the first clock edge after reset releases.
    always_ff @(posedge iClk or posedge iRst) begin
        if (iRst) begin
            readyEnR <= 1'b0;
        end else begin
            readyEnR <= 1'b1;
        end
    end

    // Beat valids plus a beat-31 tag travelling beside the lane registers.
    always_ff @(posedge iClk or posedge iRst) begin
        if (iRst) begin
            valid1R <= 1'b0;
            last1R  <= 1'b0;
            valid2R <= 1'b0;
            last2R  <= 1'b0;
        end else begin
            if (advReduceS) begin
                valid1R <= iValid;
                last1R  <= (beatCntR == BEAT_IDX_W'(BEATS_PER_POLY - 1));
            end
            if (advCompressS) begin
                valid2R <= valid1R;
                last2R  <= last1R;
            end
        end
    end

    // Input beat index within the polynomial; wraps naturally at 32.
    always_ff @(posedge iClk or posedge iRst) begin
        if (iRst) begin
            beatCntR <= '0;
        end else if (iValid && advReduceS) begin
            beatCntR <= beatCntR + BEAT_IDX_W'(1);
        end
    end

    // Packing buffer and its count of valid bits.
    always_ff @(posedge iClk or posedge iRst) begin
        if (iRst) begin
            bufR <= '0;
            cntR <= '0;
        end else begin
            bufR <= bufNextS;
            cntR <= cntNextS;
        end
    end

    // Once beat 31 is in the buffer the remaining bits are whole words, so
    // the word presented with exactly 32 bits left closes the polynomial.
    always_ff @(posedge iClk or posedge iRst) begin
        if (iRst) begin
            lastPendR <= 1'b0;
        end else if (packAcceptS && last2R) begin
            lastPendR <= 1'b1;
        end else if (emitS && oLast) begin
            lastPendR <= 1'b0;
        end
    end

`ifdef KYBER_PACK_POLYCNT_EN
    logic [15:0] polyCntR;

    // Completed-polynomial counter, wraps at 0xFFFF.
    always_ff @(posedge iClk or posedge iRst) begin
        if (iRst) begin
            polyCntR <= '0;
        end else if (emitS && oLast) begin
            polyCntR <= polyCntR + 16'd1;
        end
    end

    assign oPolyCnt = polyCntR;
`endif

    assign oReady = advReduceS;
    assign oValid = (cntR >= CNT_W'(O_WIDTH));
    assign oWord  = bufR[O_WIDTH-1:0];
    assign oLast  = lastPendR && (cntR == CNT_W'(O_WIDTH));

endmodule

// File: tb/tb_poly_reduce_compress_pack.sv
// Bench for poly_reduce_compress_pack: instance 0 runs d=4, instance 1 runs
// d=10. A golden model (true modulo, true division) fills a per-instance
// queue of expected words as beats are accepted; a monitor pops and compares
// whenever a word is handed downstream.
module tb_poly_reduce_compress_pack;

    localparam int DV [2] = '{4, 10};

    typedef struct {
        logic [31:0] word;
        logic        last;
    } exp_t;

    typedef struct {
        logic [127:0] coeffs;
        logic [31:0]  expWord;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [127:0] coeffs [2];
    logic [1:0]  inValid;
    logic [1:0]  dutReady;
    logic [31:0] outWord [2];
    logic [1:0]  outValid;
    logic [1:0]  downReady;
    logic [1:0]  outLast;
`ifdef KYBER_PACK_POLYCNT_EN
    logic [15:0] polyCnt [2];
`endif

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    exp_t        q0[$];
    exp_t        q1[$];
    logic [255:0] mBuf [2];
    int          mCnt [2];
    int          mBeat [2];
    int          words [2];
    int          lasts [2];
    int          firstCyc [2];
    int          lastCyc [2];
    logic [31:0] firstWord [2];
    logic [1:0]  bpSeen;
    logic [1:0]  readyRand;
    logic [1:0]  prevStall;
    logic [31:0] heldWord [2];
    logic [1:0]  heldLast;
    vec_t        tbl [6];

    always #5 clk = ~clk;

    poly_reduce_compress_pack #(.D_BITS(4)) dut0 (
        .iClk(clk), .iRst(rst), .iCoeffs(coeffs[0]), .iValid(inValid[0]),
        .oReady(dutReady[0]), .oWord(outWord[0]), .oValid(outValid[0]),
        .iReady(downReady[0]), .oLast(outLast[0])
`ifdef KYBER_PACK_POLYCNT_EN
        , .oPolyCnt(polyCnt[0])
`endif
    );

    poly_reduce_compress_pack #(.D_BITS(10)) dut1 (
        .iClk(clk), .iRst(rst), .iCoeffs(coeffs[1]), .iValid(inValid[1]),
        .oReady(dutReady[1]), .oWord(outWord[1]), .oValid(outValid[1]),
        .iReady(downReady[1]), .oLast(outLast[1])
`ifdef KYBER_PACK_POLYCNT_EN
        , .oPolyCnt(polyCnt[1])
`endif
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic int qsize(input int i);
        if (i == 0) return q0.size();
        else return q1.size();
    endfunction

    function automatic logic [15:0] goldenComp(input logic [15:0] x, input int d);
        int r;
        int c;
        r = int'($signed(x)) % 3329;
        if (r < 0) r = r + 3329;
        c = ((r << d) + 1664) / 3329;
        return 16'(c % (1 << d));
    endfunction

    task automatic clearModel(input int i);
        mBuf[i] = '0; mCnt[i] = 0; mBeat[i] = 0;
        words[i] = 0; lasts[i] = 0; firstCyc[i] = -1; lastCyc[i] = -1;
        firstWord[i] = '0; bpSeen[i] = 1'b0;
        if (i == 0) q0.delete();
        else q1.delete();
    endtask

    // Appends one accepted beat to the model and queues every complete word.
    task automatic modelBeat(input int i, input logic [127:0] cf);
        logic [255:0] bits;
        exp_t e;
        bits = '0;
        for (int k = 0; k < 8; k++)
            bits = bits | (256'(goldenComp(cf[16*k +: 16], DV[i])) << (k * DV[i]));
        mBuf[i] = mBuf[i] | (bits << mCnt[i]);
        mCnt[i] = mCnt[i] + 8 * DV[i];
        while (mCnt[i] >= 32) begin
            e.word  = mBuf[i][31:0];
            mBuf[i] = mBuf[i] >> 32;
            mCnt[i] = mCnt[i] - 32;
            e.last  = (mBeat[i] == 31) && (mCnt[i] == 0);
            if (i == 0) q0.push_back(e);
            else q1.push_back(e);
        end
        mBeat[i] = (mBeat[i] + 1) % 32;
    endtask

    task automatic mon(input int i);
        exp_t e;
        if (rst) begin
            prevStall[i] = 1'b0;
            return;
        end
        if (prevStall[i]) begin
            check($sformatf("hold%0d_valid", i), outValid[i], 1'b1);
            check($sformatf("hold%0d_word", i), outWord[i], heldWord[i]);
            check($sformatf("hold%0d_last", i), outLast[i], heldLast[i]);
        end
        if (outValid[i] && downReady[i]) begin
            if (qsize(i) == 0) begin
                check($sformatf("sb%0d_extra_word", i), outValid[i], 1'b0);
            end else begin
                if (i == 0) e = q0.pop_front();
                else e = q1.pop_front();
                check($sformatf("sb%0d_word", i), outWord[i], e.word);
                check($sformatf("sb%0d_last", i), outLast[i], e.last);
                if (words[i] == 0) begin
                    firstCyc[i]  = cyc;
                    firstWord[i] = outWord[i];
                end
                words[i]++;
                if (outLast[i]) begin
                    lasts[i]++;
                    lastCyc[i] = cyc;
                end
            end
        end
        prevStall[i] = outValid[i] && !downReady[i];
        heldWord[i]  = outWord[i];
        heldLast[i]  = outLast[i];
    endtask

    // Entered and left just after a rising edge.
    task automatic driveBeat(input int i, input logic [127:0] cf, input bit gaps);
        bit acc;
        int budget;
        if (gaps && $urandom_range(0, 2) == 0) begin
            inValid[i] = 1'b0;
            repeat ($urandom_range(1, 3)) begin
                @(posedge clk); #1;
            end
        end
        coeffs[i]  = cf;
        inValid[i] = 1'b1;
        acc = 1'b0;
        budget = 0;
        while (!acc && budget < 200) begin
            @(negedge clk);
            acc = dutReady[i];
            if (!dutReady[i]) bpSeen[i] = 1'b1;
            @(posedge clk); #1;
            budget++;
        end
        inValid[i] = 1'b0;
        if (acc) modelBeat(i, cf);
        else check($sformatf("hs%0d_timeout", i), acc, 1'b1);
    endtask

    task automatic drivePoly(input int i, input int nbeats, input int mode, input bit gaps);
        logic [127:0] cf;
        for (int b = 0; b < nbeats; b++) begin
            if (mode == 1) cf = {8{16'd1665}};
            else cf = {$urandom, $urandom, $urandom, $urandom};
            driveBeat(i, cf, gaps);
        end
    endtask

    task automatic drain(input int i);
        int budget;
        budget = 0;
        while (qsize(i) != 0 && budget < 1000) begin
            @(posedge clk);
            budget++;
        end
        repeat (4) @(posedge clk);
        #1;
        check($sformatf("drain%0d_left", i), qsize(i), 0);
    endtask

    task automatic applyReset();
        rst = 1'b1;
        inValid = 2'b00;
        @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            check($sformatf("rst%0d_valid", i), outValid[i], 1'b0);
            check($sformatf("rst%0d_last", i), outLast[i], 1'b0);
            check($sformatf("rst%0d_word", i), outWord[i], 32'h0);
            check($sformatf("rst%0d_ready", i), dutReady[i], 1'b0);
`ifdef KYBER_PACK_POLYCNT_EN
            check($sformatf("rst%0d_polycnt", i), polyCnt[i], 16'h0);
`endif
            clearModel(i);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        @(negedge clk);
        for (int i = 0; i < 2; i++)
            check($sformatf("postrst%0d_ready", i), dutReady[i], 1'b1);
        @(posedge clk); #1;
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        tbl[0] = '{{16'd0, 16'd0, 16'd3329, 16'hFFFF, 16'd7000, 16'd832, 16'd1665, 16'd0}, 32'h0000_2480};
        tbl[1] = '{{8{16'd0}}, 32'h0000_0000};
        tbl[2] = '{{8{16'd1665}}, 32'h8888_8888};
        tbl[3] = '{{8{16'hFFFF}}, 32'h0000_0000};
        tbl[4] = '{{16'd0, 16'd0, 16'd0, 16'd0, 16'd209, 16'd1665, 16'h8000, 16'h7FFF}, 32'h0000_183D};
        tbl[5] = '{{8{16'd3328}}, 32'h0000_0000};

        inValid   = 2'b00;
        coeffs[0] = '0;
        coeffs[1] = '0;
        readyRand = 2'b00;
        downReady = 2'b11;
        prevStall = 2'b00;
        for (int i = 0; i < 2; i++) clearModel(i);

        fork
            forever begin
                @(negedge clk);
                cyc++;
                mon(0);
                mon(1);
            end
            forever begin
                @(posedge clk); #1;
                for (int i = 0; i < 2; i++)
                    downReady[i] = readyRand[i] ? 1'($urandom_range(0, 1)) : 1'b1;
            end
        join_none

        #1 rst = 1'b1;
        applyReset();

        // Single beats at d=4 with exact three-cycle latency.
        for (int v = 0; v < 6; v++) begin
            coeffs[0]  = tbl[v].coeffs;
            inValid[0] = 1'b1;
            @(negedge clk);
            check($sformatf("tbl%0d_ready", v), dutReady[0], 1'b1);
            @(posedge clk); #1;
            inValid[0] = 1'b0;
            modelBeat(0, tbl[v].coeffs);
            @(posedge clk);
            @(negedge clk);
            check($sformatf("tbl%0d_early", v), outValid[0], 1'b0);
            @(posedge clk);
            @(negedge clk);
            check($sformatf("tbl%0d_valid", v), outValid[0], 1'b1);
            check($sformatf("tbl%0d_word", v), outWord[0], tbl[v].expWord);
            @(posedge clk); #1;
        end
        applyReset();

        // d=4 full polynomial, always ready: one word per cycle.
        drivePoly(0, 32, 0, 1'b0);
        drain(0);
        check("d4_words", words[0], 32);
        check("d4_lasts", lasts[0], 1);
        check("d4_spacing", lastCyc[0] - firstCyc[0], 31);

        // d=10 constant 1665: every 10-bit field is 0x200.
        drivePoly(1, 32, 1, 1'b0);
        drain(1);
        check("d10_words", words[1], 80);
        check("d10_lasts", lasts[1], 1);
        check("d10_first_word", firstWord[1], 32'h2008_0200);
        check("d10_backpressure", bpSeen[1], 1'b1);
        applyReset();

        // Random downstream ready and upstream gaps on both widths.
        readyRand = 2'b11;
        drivePoly(0, 32, 0, 1'b1);
        drivePoly(1, 32, 0, 1'b1);
        drain(0);
        drain(1);
        check("rnd4_words", words[0], 32);
        check("rnd4_lasts", lasts[0], 1);
        check("rnd10_words", words[1], 80);
        check("rnd10_lasts", lasts[1], 1);
        readyRand = 2'b00;
        applyReset();

        // Reset after beat 17, then a fresh polynomial.
        drivePoly(0, 18, 0, 1'b0);
        rst = 1'b1;
        #1;
        check("midrst_valid", outValid[0], 1'b0);
        check("midrst_word", outWord[0], 32'h0);
        check("midrst_last", outLast[0], 1'b0);
        check("midrst_ready", dutReady[0], 1'b0);
        applyReset();
        drivePoly(0, 32, 0, 1'b0);
        drain(0);
        check("fresh_words", words[0], 32);
        check("fresh_lasts", lasts[0], 1);

        // Two more polynomials for the frame counter.
        drivePoly(0, 64, 0, 1'b0);
        drain(0);
        check("three_poly_lasts", lasts[0], 3);
`ifdef KYBER_PACK_POLYCNT_EN
        check("polycnt", polyCnt[0], 16'd3);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
